// File: rtl/axi_lite_initiator_if.sv
// Command-port bus between the initiator and the accelerator responder:
// write address, write data, read address and read data channels.
interface axi_lite_initiator_if;
    logic        AWVALID;
    logic [31:0] AWADDR;
    logic        AWREADY;
    logic        WDVALID;
    logic [31:0] WDATA;
    logic        WDREADY;
    logic        ARVALID;
    logic [31:0] ARADDR;
    logic        ARREADY;
    logic        RDREADY;
    logic        RDVALID;
    logic [31:0] RDATA;

    modport master (
        output AWVALID, AWADDR, WDVALID, WDATA, ARVALID, ARADDR, RDREADY,
        input  AWREADY, WDREADY, ARREADY, RDVALID, RDATA
    );
    modport slave (
        input  AWVALID, AWADDR, WDVALID, WDATA, ARVALID, ARADDR, RDREADY,
        output AWREADY, WDREADY, ARREADY, RDVALID, RDATA
    );
endinterface

// File: rtl/axi_lite_initiator.sv
// Queues host commands and runs each as one write (AW then W) or read (AR then R)
// bus transaction, returning one response per command.
module axi_lite_initiator #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_write,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    axi_lite_initiator_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] data;
    } cmd_t;

    typedef enum logic [2:0] {IDLE, WADDR, WDAT, RADDR, RDAT, RESP} state_t;

    cmd_t          mem [DEPTH];
    cmd_t          head;
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          empty, full, push, pop;
    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic          seen, expired, exempt, to_err;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign busy      = (state != IDLE) || !empty;
    assign expired   = (TIMEOUT != 0) && (cnt == TO_CNT);
    // A matmul run can legitimately hold off WDREADY for a very long time.
    assign exempt    = (bus.AWADDR[23:20] == 4'h1);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= '{write: cmd_write, addr: cmd_addr, data: cmd_wdata};
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        to_err  = 1'b0;
        unique case (state)
            IDLE: if (!empty) begin
                pop     = 1'b1;
                state_n = head.write ? WADDR : RADDR;
            end
            WADDR: if (bus.AWREADY) state_n = WDAT;
                   else if (expired) begin state_n = RESP; to_err = 1'b1; end
            // Data phase ends on the first low cycle after WDREADY was seen high.
            WDAT:  if (seen && !bus.WDREADY) state_n = RESP;
                   else if (expired && !exempt) begin state_n = RESP; to_err = 1'b1; end
            RADDR: if (bus.ARREADY) state_n = RDAT;
                   else if (expired) begin state_n = RESP; to_err = 1'b1; end
            RDAT:  if (seen && !bus.RDVALID) state_n = RESP;
                   else if (expired) begin state_n = RESP; to_err = 1'b1; end
            RESP:  if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            seen        <= 1'b0;
            bus.AWVALID <= 1'b0;
            bus.AWADDR  <= '0;
            bus.WDVALID <= 1'b0;
            bus.WDATA   <= '0;
            bus.ARVALID <= 1'b0;
            bus.ARADDR  <= '0;
            bus.RDREADY <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_write   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);

            if (state_n != state) begin
                cnt  <= '0;
                seen <= 1'b0;
            end else begin
                cnt  <= cnt + CW'(1);
                if ((state == WDAT && bus.WDREADY) || (state == RDAT && bus.RDVALID)) seen <= 1'b1;
            end

            bus.AWVALID <= (state_n == WADDR);
            bus.WDVALID <= (state_n == WDAT);
            bus.ARVALID <= (state_n == RADDR);
            bus.RDREADY <= (state_n == RDAT);
            rsp_valid   <= (state_n == RESP);

            if (pop) begin
                rsp_write <= head.write;
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
                if (head.write) begin
                    bus.AWADDR <= head.addr;
                    bus.WDATA  <= head.data;
                end else begin
                    bus.ARADDR <= head.addr;
                end
            end else if (to_err) begin
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
            end else if (state == RDAT && bus.RDVALID) begin
                rsp_rdata <= bus.RDATA;
            end
        end
    end
endmodule
